// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Purpose:
//   Bundles the CPU request port, the DMA request port and the shared data
//   memory port that dmem_arbiter connects together.
//
// Parameters:
//   WIDTH  - data word width
//   ADDR_W - data memory word-address width
//
// Signal groups:
//   cpu_*  - CPU access request (req/we/addr/wdata) and its grant, stall,
//            read-valid and read data
//   dma_*  - DMA access request (req/we/lock/addr/wdata) and its grant,
//            read-valid and read data
//   mem_*  - single shared dcache port; mem_rdata is combinational from
//            mem_addr
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters plus the data memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);

  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_stall;
  logic [WIDTH-1:0]  cpu_rdata;

  // DMA port
  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [WIDTH-1:0]  dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [WIDTH-1:0]  dma_rdata;

  // Shared memory port
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_stall, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_w_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_stall, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_w_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one single-ported data memory between a CPU and a DMA engine.
//   At most one requester is granted per cycle; grants are combinational
//   from the current requests and the arbitration state. A granted read
//   returns its data one cycle later with a one-cycle rvalid pulse.
//
//   Default build: round-robin between CPU and DMA on contended cycles.
//   With DMEM_ARB_FIXED_PRIO_EN defined: the CPU wins every contended
//   cycle, except that a DMA denied for STARVE_LIMIT consecutive request
//   cycles wins the next contended cycle.
//
//   In both builds a DMA grant with dma_lock=1 locks the memory to the DMA
//   until the DMA drops either dma_req or dma_lock.
//
// Parameters:
//   WIDTH        - data word width
//   ADDR_W       - data memory word-address width
//   STARVE_LIMIT - consecutive denied DMA request cycles tolerated in the
//                  fixed-priority build
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high; abandons any lock, clears read-valid
//           and read-data registers, and forces all grants low while held
//   bus   - dmem_arbiter_if.slave: CPU port, DMA port and shared memory port
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_LAST = 2'd1,
    DMA_LAST = 2'd2,
    DMA_LOCK = 2'd3
  } state_t;

  state_t            state_q;

  logic              lock_hold_p0;
  state_t            arb_state_p0;
  logic              contended_p0;
  logic              cpu_gnt_p0;
  logic              dma_gnt_p0;
  logic              cpu_rd_p0;
  logic              dma_rd_p0;

  logic              cpu_vld_p1;
  logic              dma_vld_p1;
  logic [WIDTH-1:0]  cpu_rdata_p1;
  logic [WIDTH-1:0]  dma_rdata_p1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic              dma_starved_p0;

  assign dma_starved_p0 = (starve_cnt == LIMIT_C);
`endif

  // ---------------------------------------------------------------------------
  // Stage p0: combinational arbitration and memory port mux
  // ---------------------------------------------------------------------------

  // The lock is only held while the DMA keeps both req and lock high; the
  // first cycle either drops is arbitrated as if the DMA had just been served.
  assign lock_hold_p0 = (state_q == DMA_LOCK) && bus.dma_req && bus.dma_lock;
  assign arb_state_p0 = (state_q == DMA_LOCK) ? DMA_LAST : state_q;
  assign contended_p0 = bus.cpu_req && bus.dma_req;

  always_comb begin
    cpu_gnt_p0 = 1'b0;
    dma_gnt_p0 = 1'b0;
    if (reset) begin
      cpu_gnt_p0 = 1'b0;
      dma_gnt_p0 = 1'b0;
    end else if (lock_hold_p0) begin
      dma_gnt_p0 = 1'b1;
    end else if (contended_p0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (dma_starved_p0) begin
        dma_gnt_p0 = 1'b1;
      end else begin
        cpu_gnt_p0 = 1'b1;
      end
`else
      if (arb_state_p0 == DMA_LAST) begin
        cpu_gnt_p0 = 1'b1;
      end else begin
        dma_gnt_p0 = 1'b1;
      end
`endif
    end else begin
      cpu_gnt_p0 = bus.cpu_req;
      dma_gnt_p0 = bus.dma_req;
    end
  end

  assign cpu_rd_p0 = cpu_gnt_p0 && !bus.cpu_we;
  assign dma_rd_p0 = dma_gnt_p0 && !bus.dma_we;

  always_comb begin
    bus.mem_w_en  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt_p0) begin
      bus.mem_w_en  = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt_p0) begin
      bus.mem_w_en  = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_p0;
  assign bus.dma_gnt   = dma_gnt_p0;
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt_p0;

  // ---------------------------------------------------------------------------
  // Stage p1: arbitration state and registered read returns
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_vld_p1   <= 1'b0;
      dma_vld_p1   <= 1'b0;
      cpu_rdata_p1 <= '0;
      dma_rdata_p1 <= '0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      starve_cnt   <= '0;
`endif
    end else begin
      if (lock_hold_p0) begin
        state_q <= DMA_LOCK;
      end else if (dma_gnt_p0) begin
        state_q <= bus.dma_lock ? DMA_LOCK : DMA_LAST;
      end else if (cpu_gnt_p0) begin
        state_q <= CPU_LAST;
      end else begin
        state_q <= arb_state_p0;
      end

      cpu_vld_p1 <= cpu_rd_p0;
      dma_vld_p1 <= dma_rd_p0;
      if (cpu_rd_p0) begin
        cpu_rdata_p1 <= bus.mem_rdata;
      end
      if (dma_rd_p0) begin
        dma_rdata_p1 <= bus.mem_rdata;
      end

`ifdef DMEM_ARB_FIXED_PRIO_EN
      // Counts an unbroken run of denied DMA request cycles, saturating at
      // the limit; any DMA grant or idle DMA cycle ends the run.
      if (dma_gnt_p0 || !bus.dma_req) begin
        starve_cnt <= '0;
      end else if (!dma_starved_p0) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
`endif
    end
  end

  assign bus.cpu_rvalid = cpu_vld_p1;
  assign bus.dma_rvalid = dma_vld_p1;
  assign bus.cpu_rdata  = cpu_rdata_p1;
  assign bus.dma_rdata  = dma_rdata_p1;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the data memory word-address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive denied DMA request cycles in fixed-priority mode.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Ports cpu_req/cpu_we, input, 1 each: CPU access request and write enable.
REQ-007 Ports cpu_addr, input, ADDR_W, and cpu_wdata, input, WIDTH: CPU address and write data.
REQ-008 Ports cpu_gnt/cpu_rvalid/cpu_stall, output, 1 each: grant, read-data valid, and pipeline stall to the CPU.
REQ-009 Port cpu_rdata, output, WIDTH: registered read data to the CPU.
REQ-010 Ports dma_req/dma_we/dma_lock, input, 1 each: DMA request, write enable, and burst lock.
REQ-011 Ports dma_addr, input, ADDR_W, and dma_wdata, input, WIDTH: DMA address and write data.
REQ-012 Ports dma_gnt/dma_rvalid, output, 1 each, and dma_rdata, output, WIDTH: DMA grant, read valid, and read data.
REQ-013 Ports mem_w_en, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, WIDTH: single shared dcache port.
REQ-014 Port mem_rdata, input, WIDTH: dcache read data, combinational from mem_addr.

Function
REQ-015 The arbiter SHALL grant at most one requester per cycle, and gnt SHALL be combinational from the current requests and state.
REQ-016 mem_addr/mem_wdata SHALL mux from the granted requester; mem_w_en SHALL equal the granted requester's we; with no grant, mem_w_en=0 and mem_addr=0.
REQ-017 A granted read (we=0) SHALL capture mem_rdata into that requester's rdata register and assert its rvalid for exactly one cycle, on the following cycle (latency 1).
REQ-018 A granted write SHALL NOT assert rvalid; rdata registers SHALL hold value when not loaded.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT cpu_gnt.
REQ-020 FSM states are IDLE, CPU_LAST, DMA_LAST, DMA_LOCK; reset state IDLE.
REQ-021 IDLE or CPU_LAST with both requesting: grant DMA; DMA_LAST with both requesting: grant CPU (round-robin).
REQ-022 A single requester SHALL be granted in any state except DMA_LOCK.
REQ-023 Next state SHALL be CPU_LAST after a CPU grant and DMA_LAST after a DMA grant without dma_lock; it SHALL remain unchanged when there is no grant.
REQ-024 A DMA grant with dma_lock=1 SHALL enter DMA_LOCK; in DMA_LOCK only DMA is granted, and the CPU stalls.
REQ-025 DMA_LOCK SHALL exit to DMA_LAST on the first cycle that dma_req=0 or dma_lock=0; that cycle is arbitrated as DMA_LAST.
REQ-026 Simultaneous CPU read and DMA write SHALL serialize per REQ-021; the loser retries by holding req.

Reset
REQ-027 Reset SHALL set the FSM to IDLE, starvation counter to 0, cpu_rvalid=dma_rvalid=0, and cpu_rdata=dma_rdata=0.
REQ-028 During reset, all gnt outputs and mem_w_en SHALL be 0, and cpu_stall SHALL equal cpu_req.
REQ-029 Reset asserted mid-lock SHALL abandon the lock, and any read captured that cycle SHALL NOT raise rvalid.

Configuration
REQ-030 With macro DMEM_ARB_FIXED_PRIO_EN defined, the round-robin rule of REQ-021 SHALL be replaced: CPU wins every contended cycle.
REQ-031 Under DMEM_ARB_FIXED_PRIO_EN, a saturating counter SHALL count consecutive cycles with dma_req=1 and dma_gnt=0 and SHALL clear on a DMA grant.
REQ-032 Under DMEM_ARB_FIXED_PRIO_EN, DMA SHALL win the contended cycle when the counter equals STARVE_LIMIT.
REQ-033 Without DMEM_ARB_FIXED_PRIO_EN, no counter SHALL be built and REQ-021 applies; DMA_LOCK behaves identically in both builds.

Verification
REQ-034 The bench SHALL cover: reset, then CPU read addr 5 with mem[5]=0xDEADBEEF -> cpu_gnt same cycle; next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF.
REQ-035 The bench SHALL cover: both requesting for 4 cycles from IDLE (round-robin build) -> grants DMA, CPU, DMA, CPU, and cpu_stall=1 in cycles 1 and 3.
REQ-036 The bench SHALL cover: DMA write 0x11 to addr 2 with dma_lock=1 for 3 cycles while CPU requests -> CPU stalled 3 cycles and granted on cycle 4.
REQ-037 The bench SHALL cover: fixed-priority build with both requesting continuously, STARVE_LIMIT=4 -> 4 CPU grants, 1 DMA grant, repeating.
REQ-038 The bench SHALL cover: reset asserted during DMA_LOCK -> next cycle state IDLE, no rvalid, and CPU granted immediately after release.
REQ-039 The bench SHALL cover: DMA write 0xA5 to addr 63, then CPU read addr 63 -> cpu_rdata=0xA5 one cycle after the grant.
